// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/NOP constants and
// RISC-V instruction field slices used by the fetch unit and its neighbours.
package rv_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   // All-zero word decodes as opcode 0, which the control unit treats as illegal.
   localparam logic [31:0] FAULT_INSTR       = 32'h0000_0000;
   localparam logic [31:0] PC_STEP           = 32'd4;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_W   = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_W   = 3;

   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
      return instr[OPCODE_LSB +: OPCODE_W];
   endfunction

   function automatic logic [FUNCT3_W-1:0] funct3_of(input logic [31:0] instr);
      return instr[FUNCT3_LSB +: FUNCT3_W];
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and
// the held-instruction interface towards decode/execute.
interface instr_fetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;
   logic [31:0] dec_pc;
   logic        fetch_fault;

   modport master (
      output imem_req_valid, imem_req_addr,
      output dec_valid, dec_instr, dec_opcode, dec_funct3, dec_pc, fetch_fault,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc, dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      input  dec_valid, dec_instr, dec_opcode, dec_funct3, dec_pc, fetch_fault,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc, dec_ready
   );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem read, held instruction for execute.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned PCs into a held fault instruction.
module instr_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_unit_if.master  bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_dec_instr;
   logic [31:0]  r_dec_pc;
   logic         r_kill;
   logic         r_fault;

   logic [31:0]  w_redirect_pc;
   logic         w_misaligned;
   logic         w_req_valid;
   logic         w_req_fire;

   // Without the trap, a redirect target is silently word-aligned.
   assign w_redirect_pc = TRAP_EN ? bus.redirect_pc : word_align(bus.redirect_pc);
   assign w_misaligned  = TRAP_EN && (r_pc[1:0] != 2'b00);
   assign w_req_valid   = (r_state == ST_REQ) && !w_misaligned;
   assign w_req_fire    = w_req_valid && bus.imem_req_ready;

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.dec_valid      = (r_state == ST_HOLD);
   assign bus.dec_instr      = r_dec_instr;
   assign bus.dec_opcode     = opcode_of(r_dec_instr);
   assign bus.dec_funct3     = funct3_of(r_dec_instr);
   assign bus.dec_pc         = r_dec_pc;
   assign bus.fetch_fault    = TRAP_EN ? r_fault : 1'b0;

   // NOTE: all state updates use non-blocking assignments so every branch reads
   // the pre-edge values of r_pc/r_kill, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC;
         r_dec_pc    <= RESET_PC;
         r_dec_instr <= NOP_INSTR;
         r_kill      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_REQ;

            ST_REQ: begin
               if (bus.redirect_valid) begin
                  r_pc <= w_redirect_pc;
                  // Old address already handed to memory: its response must be dropped.
                  if (w_req_fire) begin
                     r_kill  <= 1'b1;
                     r_state <= ST_WAIT;
                  end
               end else if (w_misaligned) begin
                  r_dec_instr <= FAULT_INSTR;
                  r_dec_pc    <= r_pc;
                  r_fault     <= 1'b1;
                  r_state     <= ST_HOLD;
               end else if (w_req_fire) begin
                  r_state <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (bus.redirect_valid) begin
                  r_pc <= w_redirect_pc;
                  if (bus.imem_rsp_valid) begin
                     r_kill  <= 1'b0;
                     r_state <= ST_REQ;
                  end else begin
                     r_kill <= 1'b1;
                  end
               end else if (bus.imem_rsp_valid) begin
                  if (r_kill) begin
                     r_kill  <= 1'b0;
                     r_state <= ST_REQ;
                  end else begin
                     r_dec_instr <= bus.imem_rsp_data;
                     r_dec_pc    <= r_pc;
                     r_state     <= ST_HOLD;
                  end
               end
            end

            ST_HOLD: begin
               if (bus.redirect_valid) begin
                  r_pc        <= w_redirect_pc;
                  r_dec_instr <= NOP_INSTR;
                  r_fault     <= 1'b0;
                  r_state     <= ST_REQ;
               end else if (bus.dec_ready) begin
                  r_pc    <= r_pc + PC_STEP;
                  r_fault <= 1'b0;
                  r_state <= ST_REQ;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
